decoder_scan: RTL and testbench
===============================

# decoder_scan

Parametrised, registered binary-to-one-hot decoder with a built-in scan sequencer. In DECODE mode it latches a select code through a valid/ready handshake and drives the matching one-hot line. In SCAN mode it walks the one-hot output across all lines with a programmable dwell time. It sits between control logic and one-hot consumers such as digit/row enables, chip selects and multiplexed displays. It is the parametrised successor of the team's combinational 3-to-8 decoder.

## Interface
- SEL_W, 3, select code width
- OUT_W, 2**SEL_W, one-hot output width; must equal 2**SEL_W
- DWELL_W, 8, dwell counter width
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- en  in  1  global enable; 0 freezes all state and outputs
- mode  in  1  0 = DECODE, 1 = SCAN
- din  in  SEL_W  select code (DECODE mode)
- in_valid  in  1  din valid
- in_ready  out  1  combinational; = en & ~mode
- dwell  in  DWELL_W  cycles per scan position minus 1
- dout  out  OUT_W  registered one-hot output; all-zero when idle
- idx  out  SEL_W  registered binary index of the active line
- out_valid  out  1  registered; dout holds a valid selection
- wrap  out  1  registered one-cycle pulse on scan wrap OUT_W-1 -> 0

## Operation
- States: IDLE, DECODE, SCAN.
- Reset (rst=1 at edge), regardless of en or mode:
  - state=IDLE, dout=0, idx=0, out_valid=0, wrap=0, dwell counter=0.
  - rst has priority over every other input.
- en=0: no state, counter or output register changes, except that wrap is cleared to 0. in_ready=0.
- IDLE:
  - mode=0 with handshake (in_valid & in_ready): go to DECODE, dout=1<<din, idx=din, out_valid=1.
  - mode=1: go to SCAN, dout=1, idx=0, out_valid=1, counter=0.
  - Otherwise hold, with dout=0.
- DECODE:
  - Each accepted handshake reloads dout/idx from din; back-to-back accepts occur every cycle.
  - Without a handshake, the last selection holds.
  - mode=1: go to SCAN, restart at idx 0 with counter cleared.
- SCAN:
  - Counter increments each enabled cycle.
  - When counter==dwell: counter=0, idx=idx+1 modulo OUT_W, dout rotates left by 1.
  - On the OUT_W-1 -> 0 step, wrap=1 for exactly one cycle; otherwise wrap=0.
  - dwell is compared live. If dwell drops below the current counter value, advance when the counter wraps naturally at 2**DWELL_W-1; no forced advance.
  - in_valid is ignored (in_ready=0).
  - mode=0: go to DECODE, holding current dout/idx, until the first handshake.
- Invariant: dout is all-zero or exactly one-hot, and dout == 1<<idx whenever out_valid=1.

## Timing
- Decode latency is 1 cycle: a handshake at edge N updates dout, idx and out_valid after edge N.
- Scan step period is dwell+1 enabled cycles. The first step after entry occurs dwell+1 cycles after the entry edge.
- A full scan cycle takes OUT_W*(dwell+1) enabled cycles. wrap asserts once per full cycle, coincident with dout=1.
- A mode change takes effect at the next edge, with no bubble cycle.
- Reset mid-scan or mid-decode clears outputs at that edge. The next operation starts from IDLE one cycle later.

## Test plan
- Reset, then DECODE with SEL_W=3: send din=5, 0, 7 back-to-back with in_valid=1 -> dout=0x20, 0x01, 0x80 on successive cycles, idx=5, 0, 7, out_valid=1 from the first cycle.
- SCAN with dwell=0 from reset -> dout 0x01, 0x02, …, 0x80, 0x01 changing every cycle; wrap high only on the cycle dout returns to 0x01.
- SCAN with dwell=3 -> each position holds 4 cycles; a full cycle takes 32 cycles with one wrap pulse.
- en=0 for 5 cycles mid-scan at dout=0x08 -> dout, idx and counter frozen, wrap=0, in_ready=0; resume continues the remaining dwell.
- Switch SCAN to DECODE at dout=0x10 -> dout holds 0x10 until a handshake with din=2 gives dout=0x04. Switching back to SCAN restarts at dout=0x01.
- Assert rst during SCAN with dwell=2 -> next cycle dout=0, idx=0, out_valid=0, wrap=0.
- Parametrise SEL_W=4 and repeat the dwell=0 scan -> 16 distinct one-hot values, wrap period 16.

Source files
------------

// File: rtl/decoder_scan_if.sv
// Handshake and output bundle for decoder_scan: select/scan controls in, one-hot selection out.
interface decoder_scan_if #(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 2**SEL_W,
    parameter int DWELL_W = 8
);
    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   din;
    logic               in_valid;
    logic               in_ready;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   dout;
    logic [SEL_W-1:0]   idx;
    logic               out_valid;
    logic               wrap;

    modport master (
        output en, mode, din, in_valid, dwell,
        input  in_ready, dout, idx, out_valid, wrap
    );

    modport slave (
        input  en, mode, din, in_valid, dwell,
        output in_ready, dout, idx, out_valid, wrap
    );
endinterface

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with a scan sequencer that walks the
// active line across all outputs with a programmable dwell per position.
module decoder_scan #(
    parameter int SEL_W   = 3,
    parameter int OUT_W   = 2**SEL_W,
    parameter int DWELL_W = 8
) (
    input logic           clk,
    input logic           rst,
    decoder_scan_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;

    localparam logic [OUT_W-1:0] FIRST = OUT_W'(1);

    state_t             state;
    logic [OUT_W-1:0]   dout_q;
    logic [OUT_W-1:0]   dec;
    logic [SEL_W-1:0]   idx_q;
    logic [DWELL_W-1:0] cnt;
    logic               vld_q;
    logic               wrap_q;
    logic               hs;
    logic               step;

    for (genvar g = 0; g < OUT_W; g++) begin : g_dec
        assign dec[g] = (bus.din == SEL_W'(g));
    end

    assign bus.in_ready  = bus.en & ~bus.mode;
    assign hs            = bus.in_valid & bus.in_ready;
    // A live dwell below the counter never forces a step; the counter runs to
    // its natural rollover and advances there.
    assign step          = (cnt == bus.dwell) || (&cnt);

    assign bus.dout      = dout_q;
    assign bus.idx       = idx_q;
    assign bus.out_valid = vld_q;
    assign bus.wrap      = wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            dout_q <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
            wrap_q <= 1'b0;
            cnt    <= '0;
        end else begin
            wrap_q <= 1'b0;
            if (bus.en) begin
                case (state)
                    IDLE, DECODE: begin
                        if (bus.mode) begin
                            state  <= SCAN;
                            dout_q <= FIRST;
                            idx_q  <= '0;
                            vld_q  <= 1'b1;
                            cnt    <= '0;
                        end else if (hs) begin
                            state  <= DECODE;
                            dout_q <= dec;
                            idx_q  <= bus.din;
                            vld_q  <= 1'b1;
                        end
                    end
                    SCAN: begin
                        if (!bus.mode) begin
                            // Leaving scan keeps the current line until a new code arrives.
                            state <= DECODE;
                            if (hs) begin
                                dout_q <= dec;
                                idx_q  <= bus.din;
                            end
                        end else if (step) begin
                            cnt    <= '0;
                            idx_q  <= idx_q + SEL_W'(1);
                            dout_q <= {dout_q[OUT_W-2:0], dout_q[OUT_W-1]};
                            wrap_q <= (idx_q == SEL_W'(OUT_W-1));
                        end else begin
                            cnt <= cnt + DWELL_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_decoder_scan.sv
// Randomized and directed bench for decoder_scan against a time-based reference model.
module tb_decoder_scan;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    decoder_scan_if #(.SEL_W(3), .OUT_W(8),  .DWELL_W(8)) b  ();
    decoder_scan_if #(.SEL_W(4), .OUT_W(16), .DWELL_W(8)) b4 ();

    decoder_scan #(.SEL_W(3), .OUT_W(8),  .DWELL_W(8)) dut  (.clk(clk), .rst(rst), .bus(b));
    decoder_scan #(.SEL_W(4), .OUT_W(16), .DWELL_W(8)) dut4 (.clk(clk), .rst(rst), .bus(b4));

    // Model: scan position is derived from enabled cycles since scan entry.
    bit m_valid, m_scan, m_wrap;
    int m_idx, m_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int per;
        @(posedge clk);
        per = int'(b.dwell) + 1;
        if (rst) begin
            m_valid = 0; m_idx = 0; m_scan = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (b.en) begin
                if (b.mode) begin
                    if (!m_scan) begin
                        m_scan = 1; m_t = 0; m_idx = 0; m_valid = 1;
                    end else begin
                        m_t++;
                        m_idx  = (m_t / per) % 8;
                        m_wrap = (m_t % (8 * per)) == 0;
                    end
                end else begin
                    m_scan = 0;
                    if (b.in_valid) begin
                        m_idx = int'(b.din); m_valid = 1;
                    end
                end
            end
        end
        #1;
        chk("dout",      64'(b.dout),      m_valid ? (64'd1 << m_idx) : 64'd0);
        chk("idx",       64'(b.idx),       m_valid ? 64'(m_idx) : 64'd0);
        chk("out_valid", 64'(b.out_valid), 64'(m_valid));
        chk("wrap",      64'(b.wrap),      64'(m_wrap));
        chk("in_ready",  64'(b.in_ready),  64'(b.en & ~b.mode));
    endtask

    initial begin
        rst = 1; b.en = 0; b.mode = 0; b.din = 0; b.in_valid = 0; b.dwell = 0;
        b4.en = 0; b4.mode = 0; b4.din = 0; b4.in_valid = 0; b4.dwell = 0;

        // Reset takes priority even with en low and mode high.
        b.mode = 1;
        cyc(); cyc();
        chk("rst_dout", 64'(b.dout), 64'd0);
        rst = 0; b.mode = 0; b.en = 1;

        // Back-to-back decode 5, 0, 7.
        b.in_valid = 1;
        b.din = 3'd5; cyc(); chk("tp_dout5", 64'(b.dout), 64'h20);
        b.din = 3'd0; cyc(); chk("tp_dout0", 64'(b.dout), 64'h01);
        b.din = 3'd7; cyc(); chk("tp_dout7", 64'(b.dout), 64'h80);
        b.in_valid = 0;
        repeat (3) cyc();

        // Random decode traffic with occasional enable drops.
        for (int i = 0; i < 40; i++) begin
            b.en = ($urandom_range(0, 7) != 0);
            b.in_valid = $urandom_range(0, 1) == 1;
            b.din = 3'($urandom_range(0, 7));
            cyc();
        end
        b.en = 1; b.in_valid = 0;

        // Scan dwell=0 from reset.
        rst = 1; cyc(); rst = 0;
        b.mode = 1; b.dwell = 0;
        repeat (18) cyc();

        // Scan dwell=3: full 32-cycle loop plus a freeze at dout=0x08.
        b.mode = 0; cyc();
        b.dwell = 3; b.mode = 1;
        repeat (14) cyc();
        chk("tp_pre_freeze", 64'(b.dout), 64'h08);
        b.en = 0;
        repeat (5) cyc();
        chk("tp_frozen", 64'(b.dout), 64'h08);
        b.en = 1;
        repeat (40) cyc();

        // Scan to decode at dout=0x10, then a handshake, then back to scan.
        b.mode = 0; cyc();
        b.dwell = 1; b.mode = 1;
        for (int i = 0; i < 100 && !(m_scan && m_idx == 4); i++) cyc();
        chk("tp_reach10", 64'(b.dout), 64'h10);
        b.mode = 0;
        repeat (3) cyc();
        chk("tp_hold10", 64'(b.dout), 64'h10);
        b.in_valid = 1; b.din = 3'd2; cyc();
        chk("tp_dec2", 64'(b.dout), 64'h04);
        b.in_valid = 0; b.mode = 1; cyc();
        chk("tp_rescan", 64'(b.dout), 64'h01);

        // Reset mid-scan with dwell=2.
        b.mode = 0; cyc();
        b.dwell = 2; b.mode = 1;
        repeat (10) cyc();
        rst = 1; cyc(); rst = 0;
        chk("tp_rst_dout", 64'(b.dout), 64'd0);
        chk("tp_rst_idx",  64'(b.idx), 64'd0);
        chk("tp_rst_vld",  64'(b.out_valid), 64'd0);
        chk("tp_rst_wrap", 64'(b.wrap), 64'd0);
        repeat (6) cyc();

        // Random mixed segments; dwell changes only outside scan.
        for (int s = 0; s < 3; s++) begin
            b.en = 1; b.mode = 0; cyc();
            b.dwell = 8'($urandom_range(0, 3));
            for (int i = 0; i < 150; i++) begin
                b.en = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 15) == 0) b.mode = ~b.mode;
                b.in_valid = $urandom_range(0, 1) == 1;
                b.din = 3'($urandom_range(0, 7));
                cyc();
            end
        end
        b.en = 0; b.mode = 0; b.in_valid = 0;

        // SEL_W=4 instance: dwell=0 scan over 16 lines.
        b4.en = 1; b4.mode = 1; b4.dwell = 0;
        for (int k = 0; k < 34; k++) begin
            @(posedge clk); #1;
            chk("w4_dout", 64'(b4.dout), 64'd1 << (k % 16));
            chk("w4_idx",  64'(b4.idx), 64'(k % 16));
            chk("w4_wrap", 64'(b4.wrap), 64'(k > 0 && (k % 16) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
